bp_cfg_link_loader: RTL
=======================

Name: bp_cfg_link_loader

Overview:
- Config-link initiator: after reset and `start_i`, issues the fixed write sequence that brings a tile out of reset.
- Sequence: freeze, reset pulse, cache/CCE modes, start PC, CCE microcode download, unfreeze.
- Sits between the testbench/host-side clock domain logic and the tile's config-register responder.
- Microcode comes from an external synchronous-read ROM.

Parameters:
- cfg_addr_width_p, 16, register address width on the link.
- cfg_data_width_p, 32, write/read data width.
- vaddr_width_p, 39, start PC width; split into lo/hi 32-bit words.
- start_pc_p, 39'h00_8000_0000, boot PC.
- num_lce_p, 2, value written to num_lce register.
- icache_mode_p / dcache_mode_p, 1 / 1, final cache modes (0 = uncached, 1 = normal).
- cce_mode_p, 1, final CCE mode.
- cce_ucode_els_p, 256, microcode words to load (≥1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin sequence; sampled only in IDLE.
- cfg_v_o  out  1  request valid.
- cfg_w_v_o  out  1  1 = write, 0 = read.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data.
- cfg_ready_i  in  1  responder accepts request.
- cfg_data_v_i  in  1  read data valid.
- cfg_data_i  in  cfg_data_width_p  read data.
- ucode_addr_o  out  $clog2(cce_ucode_els_p)  ROM address.
- ucode_data_i  in  cfg_data_width_p  ROM data, valid 1 cycle after address.
- done_o  out  1  sequence complete (sticky).
- error_o  out  1  readback mismatch (sticky).

Behaviour:
- Reset: all outputs 0; state IDLE; word counter 0.
- Handshake is valid-then-ready:
  - cfg_v_o never depends combinationally on cfg_ready_i.
  - addr/data/w_v are held stable while cfg_v_o & ~cfg_ready_i.
  - Transfer occurs on the cycle where both are high; the next request is presented the following cycle at the earliest.
- States and write order (each state issues one write and advances on transfer):
  - IDLE: advances on start_i.
  - FREEZE: 0x0002 = 1.
  - RST_SET: 0x0001 = 1.
  - RST_CLR: 0x0001 = 0.
  - CCE_UNC: 0x0060 = 0.
  - NUM_LCE: 0x0061 = num_lce_p.
  - IC_MODE: 0x0022 = icache_mode_p.
  - DC_MODE: 0x0042 = dcache_mode_p.
  - PC_LO: 0x0040 = start_pc_p[31:0].
  - PC_HI: 0x0041 = zero-extended start_pc_p[vaddr_width_p-1:32].
- UCODE_RD: drive ucode_addr_o = counter; cfg_v_o = 0; go to UCODE_WR next cycle.
- UCODE_WR:
  - Capture ucode_data_i on entry; write 0x8000 + counter.
  - On transfer: if counter == cce_ucode_els_p-1, clear counter and go to CCE_MODE; else increment and go to UCODE_RD.
- CCE_MODE: 0x0060 = cce_mode_p.
- UNFREEZE: 0x0002 = 0.
- DONE: done_o = 1, cfg_v_o = 0; stays until reset; start_i ignored.
- Address arithmetic: 0x8000 + counter zero-extended to cfg_addr_width_p; no wrap for els ≤ 4096.
- start_i asserted outside IDLE: ignored.
- reset_i mid-transfer: the next cycle is IDLE with cfg_v_o = 0; no partial request is retained.
- cfg_data_v_i outside readback: ignored.

Optional Feature:
- Macro: BP_CFG_LOADER_UCODE_VERIFY_EN.
- Defined:
  - After the last UCODE_WR, enter VRFY_RD → VRFY_REQ → VRFY_WAIT per word.
  - VRFY_RD: ROM read.
  - VRFY_REQ: cfg_w_v_o = 0 read of 0x8000 + counter.
  - VRFY_WAIT: wait for cfg_data_v_i; compare with the captured ROM word; mismatch sets error_o sticky.
  - After the last word, go to CCE_MODE. Errors do not abort the sequence.
- Undefined: no VRFY states; error_o tied 0; cfg_data_v_i and cfg_data_i unused; cfg_w_v_o always 1 when cfg_v_o.

Decomposition:
- Shared package bp_common_cfg_link_pkg gets:
  - register address constants;
  - bp_cfg_loader_state_e enum;
  - cache-mode enum (e_cfg_uncached = 0, e_cfg_normal = 1);
  - cce-mode enum.
- Single module. The ROM stays external; no sub-module is warranted.

Test Plan:
- Ready tied 1, els = 4, start pulse → writes in exact order: 0x0002=1, 0x0001=1, 0x0001=0, 0x0060=0, 0x0061=2, 0x0022=1, 0x0042=1, 0x0040=0x8000_0000, 0x0041=0, 0x8000..0x8003 = ROM words, 0x0060=1, 0x0002=0; then done_o = 1 stays high.
- Random cfg_ready_i backpressure (30% high) → identical write log; addr/data stable across every stall cycle (assertion).
- reset_i asserted while UCODE_WR stalled at word 2 → cfg_v_o = 0 next cycle; a fresh start_i replays the full sequence from FREEZE.
- start_i held high through and after DONE → exactly one sequence issued; done_o remains 1.
- VERIFY_EN, responder corrupts word 1 (returns 0xDEAD_BEEF) → error_o rises on that compare and stays 1; CCE_MODE and UNFREEZE writes still issued; done_o = 1.
- VERIFY_EN, cfg_data_v_i delayed 5 cycles per read → no extra requests while in VRFY_WAIT; error_o = 0.

Source files
------------

// File: rtl/bp_common_cfg_link_pkg.sv
// Shared config-link definitions: register map, loader FSM states, cache/CCE mode encodings.
// Imported by the config-link initiator and by anything that decodes its requests.
package bp_common_cfg_link_pkg;

    localparam logic [15:0] cfg_reg_reset_gp       = 16'h0001;
    localparam logic [15:0] cfg_reg_freeze_gp      = 16'h0002;
    localparam logic [15:0] cfg_reg_icache_mode_gp = 16'h0022;
    localparam logic [15:0] cfg_reg_start_pc_lo_gp = 16'h0040;
    localparam logic [15:0] cfg_reg_start_pc_hi_gp = 16'h0041;
    localparam logic [15:0] cfg_reg_dcache_mode_gp = 16'h0042;
    localparam logic [15:0] cfg_reg_cce_mode_gp    = 16'h0060;
    localparam logic [15:0] cfg_reg_num_lce_gp     = 16'h0061;
    localparam logic [15:0] cfg_reg_ucode_base_gp  = 16'h8000;

    typedef enum logic [4:0] {
        e_idle,
        e_freeze,
        e_rst_set,
        e_rst_clr,
        e_cce_unc,
        e_num_lce,
        e_ic_mode,
        e_dc_mode,
        e_pc_lo,
        e_pc_hi,
        e_ucode_rd,
        e_ucode_wr,
        e_vrfy_rd,
        e_vrfy_req,
        e_vrfy_wait,
        e_cce_mode,
        e_unfreeze,
        e_done
    } bp_cfg_loader_state_e;

    typedef enum logic {
        e_cfg_uncached = 1'b0,
        e_cfg_normal   = 1'b1
    } bp_cfg_cache_mode_e;

    typedef enum logic {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cfg_cce_mode_e;

endpackage

// File: rtl/bp_cfg_link_loader.sv
// Config-link initiator: replays the tile bring-up write sequence (freeze .. microcode .. unfreeze) after start_i.
// Latency: one request per state, next request no earlier than the cycle after a transfer; ROM read costs one idle cycle per word.
// Backpressure: valid-then-ready, request held stable while cfg_ready_i is low. BP_CFG_LOADER_UCODE_VERIFY_EN adds microcode readback.
module bp_cfg_link_loader
    import bp_common_cfg_link_pkg::*;
#(
    parameter int                        cfg_addr_width_p = 16,
    parameter int                        cfg_data_width_p = 32,
    parameter int                        vaddr_width_p    = 39,
    parameter logic [vaddr_width_p-1:0]  start_pc_p       = 39'h00_8000_0000,
    parameter int                        num_lce_p        = 2,
    parameter int                        icache_mode_p    = 1,
    parameter int                        dcache_mode_p    = 1,
    parameter int                        cce_mode_p       = 1,
    parameter int                        cce_ucode_els_p  = 256,
    localparam int                       ucode_addr_width_lp = (cce_ucode_els_p > 1) ? $clog2(cce_ucode_els_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    output logic                           cfg_v_o,
    output logic                           cfg_w_v_o,
    output logic [cfg_addr_width_p-1:0]    cfg_addr_o,
    output logic [cfg_data_width_p-1:0]    cfg_data_o,
    input  logic                           cfg_ready_i,
    input  logic                           cfg_data_v_i,
    input  logic [cfg_data_width_p-1:0]    cfg_data_i,
    output logic [ucode_addr_width_lp-1:0] ucode_addr_o,
    input  logic [cfg_data_width_p-1:0]    ucode_data_i,
    output logic                           done_o,
    output logic                           error_o
);

    localparam logic [63:0] start_pc_ext_lp = 64'(start_pc_p);
    localparam logic [cfg_data_width_p-1:0] pc_lo_lp = cfg_data_width_p'(start_pc_ext_lp[31:0]);
    localparam logic [cfg_data_width_p-1:0] pc_hi_lp = cfg_data_width_p'(start_pc_ext_lp[63:32]);

    function automatic logic [cfg_addr_width_p-1:0] reg_addr(input logic [15:0] a);
        return cfg_addr_width_p'(a);
    endfunction

    function automatic logic [cfg_data_width_p-1:0] reg_data(input int d);
        return cfg_data_width_p'(d);
    endfunction

    bp_cfg_loader_state_e state_q, state_n;
    logic [ucode_addr_width_lp-1:0] cnt_q, cnt_n;
    logic [cfg_data_width_p-1:0]    ucode_q;
    logic                           rom_entry_q;

    logic                           req_v;
    logic                           req_w;
    logic [cfg_addr_width_p-1:0]    req_addr;
    logic [cfg_data_width_p-1:0]    req_data;
    bp_cfg_loader_state_e           req_next;

    logic                           last_word;
    logic [cfg_addr_width_p-1:0]    ucode_reg_addr;
    logic [cfg_data_width_p-1:0]    rom_word;

    assign last_word      = (cnt_q == ucode_addr_width_lp'(cce_ucode_els_p - 1));
    assign ucode_reg_addr = reg_addr(cfg_reg_ucode_base_gp) + cfg_addr_width_p'(cnt_q);
    // ROM data is live only on the first cycle after the read; later stall cycles use the captured copy.
    assign rom_word       = rom_entry_q ? ucode_data_i : ucode_q;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        req_v    = 1'b0;
        req_w    = 1'b1;
        req_addr = '0;
        req_data = '0;
        req_next = state_q;

        unique case (state_q)
            e_idle: begin
                if (start_i) state_n = e_freeze;
            end
            e_freeze: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_freeze_gp); req_data = reg_data(1);
                req_next = e_rst_set;
            end
            e_rst_set: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_reset_gp); req_data = reg_data(1);
                req_next = e_rst_clr;
            end
            e_rst_clr: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_reset_gp); req_data = reg_data(0);
                req_next = e_cce_unc;
            end
            e_cce_unc: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_cce_mode_gp);
                req_data = cfg_data_width_p'(e_cce_mode_uncached);
                req_next = e_num_lce;
            end
            e_num_lce: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_num_lce_gp); req_data = reg_data(num_lce_p);
                req_next = e_ic_mode;
            end
            e_ic_mode: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_icache_mode_gp); req_data = reg_data(icache_mode_p);
                req_next = e_dc_mode;
            end
            e_dc_mode: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_dcache_mode_gp); req_data = reg_data(dcache_mode_p);
                req_next = e_pc_lo;
            end
            e_pc_lo: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_start_pc_lo_gp); req_data = pc_lo_lp;
                req_next = e_pc_hi;
            end
            e_pc_hi: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_start_pc_hi_gp); req_data = pc_hi_lp;
                req_next = e_ucode_rd;
            end
            e_ucode_rd: begin
                state_n = e_ucode_wr;
            end
            e_ucode_wr: begin
                req_v = 1'b1; req_addr = ucode_reg_addr; req_data = rom_word;
                if (last_word) begin
`ifdef BP_CFG_LOADER_UCODE_VERIFY_EN
                    req_next = e_vrfy_rd;
`else
                    req_next = e_cce_mode;
`endif
                    if (cfg_ready_i) cnt_n = '0;
                end else begin
                    req_next = e_ucode_rd;
                    if (cfg_ready_i) cnt_n = cnt_q + 1'b1;
                end
            end
`ifdef BP_CFG_LOADER_UCODE_VERIFY_EN
            e_vrfy_rd: begin
                state_n = e_vrfy_req;
            end
            e_vrfy_req: begin
                req_v = 1'b1; req_w = 1'b0; req_addr = ucode_reg_addr;
                req_next = e_vrfy_wait;
            end
            e_vrfy_wait: begin
                if (cfg_data_v_i) begin
                    if (last_word) begin
                        cnt_n   = '0;
                        state_n = e_cce_mode;
                    end else begin
                        cnt_n   = cnt_q + 1'b1;
                        state_n = e_vrfy_rd;
                    end
                end
            end
`endif
            e_cce_mode: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_cce_mode_gp); req_data = reg_data(cce_mode_p);
                req_next = e_unfreeze;
            end
            e_unfreeze: begin
                req_v = 1'b1; req_addr = reg_addr(cfg_reg_freeze_gp); req_data = reg_data(0);
                req_next = e_done;
            end
            e_done: begin
                state_n = e_done;
            end
            default: begin
                state_n = e_idle;
            end
        endcase

        if (req_v && cfg_ready_i) state_n = req_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_idle;
            cnt_q       <= '0;
            ucode_q     <= '0;
            rom_entry_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            rom_entry_q <= (state_q == e_ucode_rd) || (state_q == e_vrfy_rd);
            if (rom_entry_q) ucode_q <= ucode_data_i;
        end
    end

    assign cfg_v_o      = req_v;
    assign cfg_w_v_o    = req_v & req_w;
    assign cfg_addr_o   = req_addr;
    assign cfg_data_o   = req_data;
    assign ucode_addr_o = cnt_q;
    assign done_o       = (state_q == e_done);

`ifdef BP_CFG_LOADER_UCODE_VERIFY_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if ((state_q == e_vrfy_wait) && cfg_data_v_i && (cfg_data_i != ucode_q)) begin
            err_q <= 1'b1;
        end
    end

    assign error_o = err_q;
`else
    logic unused_rd_path;
    assign unused_rd_path = ^{cfg_data_v_i, cfg_data_i};
    assign error_o        = 1'b0;
`endif

endmodule
